// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, one stop bit.
// Every bit is held for the captured prescale count of CLK cycles.
module uart_tx_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   Data_Valid,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] prescale,
    output logic                   TX_OUT,
    output logic                   busy
);

    localparam int                     BIT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_W-1:0]       LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [PRESC_WIDTH-1:0] MIN_PRESC = PRESC_WIDTH'(4);
    localparam logic [PRESC_WIDTH-1:0] ONE       = PRESC_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                   state_q;
    logic [PRESC_WIDTH-1:0]   cnt_q;
    logic [PRESC_WIDTH-1:0]   presc_q;
    logic [PRESC_WIDTH-1:0]   presc_d;
    logic [BIT_W-1:0]         bit_q;
    logic [DATA_WIDTH-1:0]    shift_q;
    logic                     par_q;
    logic                     par_d;
    logic                     paren_q;
    logic                     tx_q;
    logic                     busy_q;
    logic                     cnt_done;
    logic                     start_req;
    logic                     shift_en;

    assign presc_d   = (prescale < MIN_PRESC) ? MIN_PRESC : prescale;
    assign par_d     = (^P_DATA) ^ PAR_TYP;
    assign cnt_done  = (cnt_q == (presc_q - ONE));
    assign start_req = (state_q == S_IDLE) && Data_Valid;
    // The next data bit is loaded into tx_q whenever a START or non-final DATA period ends.
    assign shift_en  = cnt_done &&
                       ((state_q == S_START) || ((state_q == S_DATA) && (bit_q != LAST_BIT)));

    // Frame contents are only ever loaded in IDLE, so later input changes cannot disturb a frame.
    always_ff @(posedge CLK) begin
        if (start_req) begin
            shift_q <= P_DATA;
            presc_q <= presc_d;
            par_q   <= par_d;
            paren_q <= PAR_EN;
        end else if (shift_en) begin
            shift_q <= shift_q >> 1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    bit_q <= '0;
                    if (Data_Valid) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (cnt_done) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_done) begin
                        cnt_q <= '0;
                        if (bit_q == LAST_BIT) begin
                            bit_q <= '0;
                            if (paren_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                            tx_q  <= shift_q[0];
                        end
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                S_PARITY: begin
                    if (cnt_done) begin
                        cnt_q   <= '0;
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                S_STOP: begin
                    if (cnt_done) begin
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed testbench for uart_tx_serializer; expected frames are hand-written bit strings
// listed in transmission order (start bit first).
module tb_uart_tx_serializer;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;

    int   tests;
    int   failed;
    logic tx_log   [0:1023];
    logic busy_log [0:1023];

    uart_tx_serializer #(
        .DATA_WIDTH (8),
        .PRESC_WIDTH(6)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .prescale  (prescale),
        .TX_OUT    (TX_OUT),
        .busy      (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Called at a negedge: presents a request that the next posedge captures.
    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        prescale   = ps;
        Data_Valid = 1'b1;
    endtask

    // Logs TX_OUT/busy at the negedge after each posedge. kind: 0 plain, 1 change inputs
    // at poke_at, 2 pulse Data_Valid at poke_at, 3 keep Data_Valid high throughout.
    task automatic record(input int ncyc, input int kind, input int poke_at);
        for (int k = 0; k < ncyc; k++) begin
            @(posedge CLK);
            @(negedge CLK);
            tx_log[k]   = TX_OUT;
            busy_log[k] = busy;
            if (k == 0 && kind != 3) Data_Valid = 1'b0;
            if (kind == 1 && k == poke_at) begin
                P_DATA   = 8'h00;
                prescale = 6'd4;
                PAR_EN   = 1'b0;
                PAR_TYP  = ~PAR_TYP;
            end
            if (kind == 2 && k == poke_at) begin
                Data_Valid = 1'b1;
                P_DATA     = 8'hFF;
            end
            if (kind == 2 && k == poke_at + 1) Data_Valid = 1'b0;
        end
    endtask

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        send(8'hA5, 1'b0, 1'b0, 6'd4);
        for (int i = 0; i < 2; i++) begin
            step();
            tests++;
            if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
                failed++;
                $display("FAIL reset_hold%0d: got tx=%b busy=%b, want tx=1 busy=0", i, TX_OUT, busy);
            end
        end
        RST = 1'b0;
        step();
        tests++;
        if (TX_OUT !== 1'b0 || busy !== 1'b1) begin
            failed++;
            $display("FAIL reset_release_start: got tx=%b busy=%b, want tx=0 busy=1", TX_OUT, busy);
        end
        RST        = 1'b1;
        Data_Valid = 1'b0;
        step();
        tests++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL reset_abort: got tx=%b busy=%b, want tx=1 busy=0", TX_OUT, busy);
        end
        RST = 1'b0;
        step();
    endtask

    task automatic test_frame_formats();
        logic [7:0] v_d  [5];
        logic       v_pe [5];
        logic       v_pt [5];
        logic [5:0] v_ps [5];
        string      v_f  [5];
        int         p, n;
        logic       ok, e, bad_tx, bad_busy;
        v_d  = '{8'hA5, 8'hA5, 8'hA5, 8'h07, 8'h3C};
        v_pe = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        v_pt = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        v_ps = '{6'd8, 6'd16, 6'd16, 6'd8, 6'd63};
        v_f  = '{"0101001011", "01010010101", "01010010111", "01110000011", "0001111001"};
        for (int v = 0; v < 5; v++) begin
            p = int'(v_ps[v]);
            n = v_f[v].len();
            send(v_d[v], v_pe[v], v_pt[v], v_ps[v]);
            record(n * p + 1, 0, 0);
            for (int b = 0; b < n; b++) begin
                e = (v_f[v].getc(b) == "1");
                ok = 1'b1; bad_tx = e; bad_busy = 1'b1;
                for (int c = 0; c < p; c++) begin
                    if (ok && (tx_log[b*p+c] !== e || busy_log[b*p+c] !== 1'b1)) begin
                        ok = 1'b0; bad_tx = tx_log[b*p+c]; bad_busy = busy_log[b*p+c];
                    end
                end
                tests++;
                if (!ok) begin
                    failed++;
                    $display("FAIL fmt%0d_bit%0d: got tx=%b busy=%b, want tx=%b busy=1",
                             v, b, bad_tx, bad_busy, e);
                end
            end
            tests++;
            if (busy_log[n*p] !== 1'b0 || tx_log[n*p] !== 1'b1) begin
                failed++;
                $display("FAIL fmt%0d_end: got tx=%b busy=%b at cycle %0d, want tx=1 busy=0",
                         v, tx_log[n*p], busy_log[n*p], n * p + 1);
            end
        end
    endtask

    task automatic test_capture_isolation();
        string f;
        logic  ok, e;
        f = "01110000011";
        send(8'h07, 1'b1, 1'b0, 6'd8);
        record(89, 1, 10);
        ok = 1'b1;
        for (int b = 0; b < 11; b++) begin
            e = (f.getc(b) == "1");
            for (int c = 0; c < 8; c++)
                if (tx_log[b*8+c] !== e || busy_log[b*8+c] !== 1'b1) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL isolation_frame: got a frame differing from 07/even/P8, want 01110000011 at 8 cycles/bit");
        end
        tests++;
        if (busy_log[88] !== 1'b0) begin
            failed++;
            $display("FAIL isolation_end: got busy=%b at cycle 89, want 0", busy_log[88]);
        end
    endtask

    task automatic test_busy_ignore();
        string f;
        logic  ok, e;
        f = "0101001011";
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        record(84, 2, 20);
        ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
            e = (f.getc(b) == "1");
            for (int c = 0; c < 8; c++)
                if (tx_log[b*8+c] !== e || busy_log[b*8+c] !== 1'b1) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL ignore_frame: got a frame disturbed by the mid-frame request, want 0101001011");
        end
        tests++;
        if (busy_log[80] !== 1'b0 || busy_log[81] !== 1'b0 || busy_log[83] !== 1'b0) begin
            failed++;
            $display("FAIL ignore_no_restart: got busy=%b%b%b after frame, want 000",
                     busy_log[80], busy_log[81], busy_log[83]);
        end
    endtask

    task automatic test_back_to_back();
        string f;
        logic  ok, e;
        f = "0101010101";
        send(8'h55, 1'b0, 1'b0, 6'd4);
        record(90, 3, 0);
        Data_Valid = 1'b0;
        for (int fr = 0; fr < 2; fr++) begin
            ok = 1'b1;
            for (int b = 0; b < 10; b++) begin
                e = (f.getc(b) == "1");
                for (int c = 0; c < 4; c++)
                    if (tx_log[fr*41+b*4+c] !== e || busy_log[fr*41+b*4+c] !== 1'b1) ok = 1'b0;
            end
            tests++;
            if (!ok) begin
                failed++;
                $display("FAIL b2b_frame%0d: got a frame differing from 55/P4, want 0101010101", fr);
            end
        end
        for (int g = 0; g < 2; g++) begin
            tests++;
            if (busy_log[40+g*41] !== 1'b0 || tx_log[40+g*41] !== 1'b1 || busy_log[41+g*41] !== 1'b1) begin
                failed++;
                $display("FAIL b2b_gap%0d: got busy=%b tx=%b then busy=%b, want 1 idle-high cycle then busy=1",
                         g, busy_log[40+g*41], tx_log[40+g*41], busy_log[41+g*41]);
            end
        end
        record(45, 0, 0);
        tests++;
        if (busy_log[44] !== 1'b0) begin
            failed++;
            $display("FAIL b2b_drain: got busy=%b after release, want 0", busy_log[44]);
        end
    endtask

    task automatic test_reset_midframe();
        string f;
        logic  ok, e;
        send(8'hA5, 1'b0, 1'b0, 6'd8);
        record(35, 0, 0);
        tests++;
        if (tx_log[34] !== 1'b0 || busy_log[34] !== 1'b1) begin
            failed++;
            $display("FAIL midreset_bit3: got tx=%b busy=%b, want tx=0 busy=1", tx_log[34], busy_log[34]);
        end
        RST = 1'b1;
        step();
        tests++;
        if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            failed++;
            $display("FAIL midreset_abort: got tx=%b busy=%b, want tx=1 busy=0", TX_OUT, busy);
        end
        RST = 1'b0;
        step();
        f = "0001111001";
        send(8'h3C, 1'b0, 1'b0, 6'd4);
        record(41, 0, 0);
        ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
            e = (f.getc(b) == "1");
            for (int c = 0; c < 4; c++)
                if (tx_log[b*4+c] !== e || busy_log[b*4+c] !== 1'b1) ok = 1'b0;
        end
        tests++;
        if (!ok || busy_log[40] !== 1'b0) begin
            failed++;
            $display("FAIL midreset_next_frame: got incorrect frame or busy=%b at end, want 0001111001 then busy=0",
                     busy_log[40]);
        end
    endtask

    task automatic test_clamp();
        string f;
        logic  ok, e;
        f = "0100000011";
        send(8'h81, 1'b0, 1'b0, 6'd1);
        record(41, 0, 0);
        ok = 1'b1;
        for (int b = 0; b < 10; b++) begin
            e = (f.getc(b) == "1");
            for (int c = 0; c < 4; c++)
                if (tx_log[b*4+c] !== e || busy_log[b*4+c] !== 1'b1) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            failed++;
            $display("FAIL clamp_frame: got a frame not at 4 cycles/bit, want 0100000011 at 4 cycles/bit");
        end
        tests++;
        if (busy_log[40] !== 1'b0) begin
            failed++;
            $display("FAIL clamp_end: got busy=%b at cycle 41, want 0", busy_log[40]);
        end
    endtask

    initial begin
        tests      = 0;
        failed     = 0;
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        prescale   = 6'd4;
        test_reset();
        test_frame_formats();
        test_capture_isolation();
        test_busy_ignore();
        test_back_to_back();
        test_reset_midframe();
        test_clamp();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
